// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: applies AddRoundKey locally and steps an external
// combinational round datapath once per cycle, NR rounds per block.
module aes_round_ctrl #(
  parameter int unsigned NR = 10,
  parameter int unsigned RW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [127:0]  in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [127:0]  out_data_o,
  output logic [RW-1:0] rk_idx_o,
  input  logic [127:0]  rk_in_i,
  output logic [127:0]  dp_state_o,
  output logic          dp_last_o,
  input  logic [127:0]  dp_result_i,
  output logic          busy_o
);

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  localparam logic [RW-1:0] RndLast = RW'(NR);

  state_e        st_q, st_d;
  logic [RW-1:0] rnd_q, rnd_d;
  logic [127:0]  state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q    <= StIdle;
      rnd_q   <= '0;
      state_q <= '0;
    end else begin
      st_q    <= st_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    unique case (st_q)
      StIdle: begin
        if (in_valid_i) begin
          // Round-0 AddRoundKey; rk_idx is 0 while idle.
          state_d = in_data_i ^ rk_in_i;
          rnd_d   = RW'(1);
          st_d    = StRound;
        end
      end
      StRound: begin
        state_d = dp_result_i ^ rk_in_i;
        if (rnd_q == RndLast) begin
          st_d = StDone;
        end else begin
          rnd_d = rnd_q + RW'(1);
        end
      end
      StDone: begin
        if (out_ready_i) begin
          st_d  = StIdle;
          rnd_d = '0;
        end
      end
      default: begin
        st_d  = StIdle;
        rnd_d = '0;
      end
    endcase
  end

  // Every output is decoded from registers only.
  assign in_ready_o  = (st_q == StIdle);
  assign out_valid_o = (st_q == StDone);
  assign busy_o      = (st_q != StIdle);
  assign rk_idx_o    = (st_q == StRound) ? rnd_q : '0;
  assign dp_last_o   = (st_q == StRound) && (rnd_q == RndLast);
  assign dp_state_o  = state_q;
  assign out_data_o  = state_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: real AES-128 round datapath and key schedule on one
// instance, a pass-through stub datapath on an NR=14 instance.
module tb_aes_round_ctrl;

  logic         clk;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, dp_last, busy;
  logic [127:0] in_data, out_data, rk_in, dp_state, dp_result;
  logic [3:0]   rk_idx;

  logic         s_rst;
  logic         s_in_valid, s_in_ready, s_out_valid, s_dp_last, s_busy;
  logic [127:0] s_in_data, s_out_data, s_rk_in, s_dp_state, s_dp_result;
  logic [3:0]   s_rk_idx;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]   sbox [256];
  logic [31:0]  w    [44];
  logic [127:0] rk   [11];

  localparam logic [127:0] Key  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] Pt   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Fips = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic [127:0] blocks [3];
  logic [127:0] expct  [3];

  aes_round_ctrl #(.NR(10), .RW(4)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .rk_idx_o(rk_idx), .rk_in_i(rk_in),
    .dp_state_o(dp_state), .dp_last_o(dp_last), .dp_result_i(dp_result),
    .busy_o(busy)
  );

  aes_round_ctrl #(.NR(14), .RW(4)) u_dut14 (
    .clk_i(clk), .rst_i(s_rst),
    .in_valid_i(s_in_valid), .in_ready_o(s_in_ready), .in_data_i(s_in_data),
    .out_valid_o(s_out_valid), .out_ready_i(1'b1), .out_data_o(s_out_data),
    .rk_idx_o(s_rk_idx), .rk_in_i(s_rk_in),
    .dp_state_o(s_dp_state), .dp_last_o(s_dp_last), .dp_result_i(s_dp_result),
    .busy_o(s_busy)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  function automatic logic [127:0] aes_rnd(input logic [127:0] s, input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int q = 0; q < 4; q++) t[4*c+q] = b[4*((c+q)%4)+q];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] p);
    logic [127:0] s;
    s = p ^ rk[0];
    for (int r = 1; r <= 10; r++) s = aes_rnd(s, r == 10) ^ rk[r];
    return s;
  endfunction

  assign dp_result   = aes_rnd(dp_state, dp_last);
  assign rk_in       = (rk_idx <= 4'd10) ? rk[rk_idx] : '0;
  assign s_dp_result = s_dp_state;
  assign s_rk_in     = {16{{4'b0000, s_rk_idx}}};

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic build_tables();
    logic [7:0]  inv, rcon;
    logic [31:0] tmp;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rl(inv) ^ rl(rl(inv)) ^ rl(rl(rl(inv))) ^ rl(rl(rl(rl(inv)))) ^ 8'h63;
    end
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = Key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp  = {tmp[23:0], tmp[31:24]};
        tmp  = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]}
               ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int cyc, n_acc, n_out, lat;
    int acc_cyc [3];
    logic fire_in, fire_out;
    logic [127:0] m;

    rst = 1'b1; s_rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0;
    blocks[0] = 128'h3243f6a8885a308d313198a2e0370734;
    blocks[1] = 128'hdeadbeef0123456789abcdeffedcba98;
    blocks[2] = 128'hffffffffffffffff0000000000000000;
    build_tables();
    for (int k = 0; k < 3; k++) expct[k] = aes_ref(blocks[k]);
    step(); step();
    rst = 1'b0; s_rst = 1'b0;

    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rk_idx", rk_idx, 0);
    check_eq("rst_dp_last", dp_last, 0);
    check_eq("rst_out_data", out_data, 0);

    // FIPS-197 vector with rk_idx / dp_last trace.
    in_data = Pt; in_valid = 1'b1;
    check_eq("acc_rk_idx", rk_idx, 0);
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      check_eq($sformatf("trace_rk_idx_%0d", i), rk_idx, 128'(i));
      check_eq($sformatf("trace_dp_last_%0d", i), dp_last, (i == 10) ? 1 : 0);
      check_eq($sformatf("trace_out_valid_%0d", i), out_valid, 0);
      step();
    end
    check_eq("fips_latency", out_valid, 1);
    check_eq("fips_data", out_data, Fips);

    // Backpressure in DONE with a competing in_valid.
    in_valid = 1'b1; in_data = blocks[0];
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_out_data", out_data, Fips);
      check_eq("bp_in_ready", in_ready, 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check_eq("bp_release_valid", out_valid, 1);
    step();
    out_ready = 1'b0;
    check_eq("bp_after_in_ready", in_ready, 1);
    check_eq("bp_after_out_valid", out_valid, 0);
    check_eq("bp_after_busy", busy, 0);

    // Back-to-back with in_valid held high.
    out_ready = 1'b1;
    cyc = 0; n_acc = 0; n_out = 0;
    while (n_out < 3 && cyc < 100) begin
      in_valid = (n_acc < 3);
      in_data  = (n_acc < 3) ? blocks[n_acc] : '0;
      fire_in  = in_valid & in_ready;
      fire_out = out_valid & out_ready;
      if (fire_out) begin
        check_eq($sformatf("b2b_data_%0d", n_out), out_data, expct[n_out]);
        n_out++;
      end
      step();
      cyc++;
      if (fire_in) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
    end
    in_valid = 1'b0;
    check_eq("b2b_outputs", n_out, 3);
    check_eq("b2b_spacing_01", acc_cyc[1] - acc_cyc[0], 12);
    check_eq("b2b_spacing_12", acc_cyc[2] - acc_cyc[1], 12);

    // Handshake coinciding with reset is dropped.
    in_valid = 1'b1; in_data = blocks[0]; rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check_eq("rst_hs_busy", busy, 0);
    check_eq("rst_hs_in_ready", in_ready, 1);

    // Reset at round 5.
    in_valid = 1'b1; in_data = blocks[1];
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_eq("mid_rk_idx", rk_idx, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_in_ready", in_ready, 1);
    check_eq("mid_busy", busy, 0);
    check_eq("mid_out_valid", out_valid, 0);
    check_eq("mid_out_data", out_data, 0);
    in_valid = 1'b1; in_data = blocks[2];
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    check_eq("mid_retry_latency", lat, 10);
    check_eq("mid_retry_data", out_data, expct[2]);
    step();

    // NR=14 stub datapath: XOR-accumulation of byte-replicated round indices.
    s_in_data = Pt; s_in_valid = 1'b1;
    step();
    s_in_valid = 1'b0;
    lat = 0;
    while (!s_out_valid && lat < 40) begin
      step();
      lat++;
    end
    m = Pt;
    for (int i = 1; i <= 14; i++) m = m ^ {16{8'(i)}};
    check_eq("nr14_latency", lat, 14);
    check_eq("nr14_data", s_out_data, m);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
